// File: rtl/radar_master_trigger.sv
// Radar master trigger: programmable pulse-repetition timer.
// Emits a fixed-length burst or a continuous train of trigger pulses.
module radar_master_trigger #(
    parameter int unsigned PERIOD_WIDTH = 32,
    parameter int unsigned BURST_WIDTH  = 16,
    parameter int unsigned LENGTH_WIDTH = 8
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  logic                    ipEnable,
    input  logic [PERIOD_WIDTH-1:0] ipPeriod,
    input  logic [LENGTH_WIDTH-1:0] ipPulseLength,
    input  logic [BURST_WIDTH-1:0]  ipBurstCount,
    input  logic                    ipStart,
    input  logic                    ipStop,
    output logic                    opTrigger,
    output logic                    opBusy,
    output logic [BURST_WIDTH-1:0]  opPulseIndex,
    output logic                    opBurstDone,
    output logic                    opConfigError
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [LENGTH_WIDTH-1:0] length_q, length_d;
    logic [BURST_WIDTH-1:0]  burst_q, burst_d;
    logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
    logic [BURST_WIDTH-1:0]  index_q, index_d;
    logic                    trigger_q, trigger_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    cfg_valid_c;
    logic                    phase_last_c;
    logic                    burst_last_c;
    logic                    stop_req_c;

    // Length is zero-extended so every comparison is unsigned at full period width.
    assign cfg_valid_c  = (ipPeriod >= PERIOD_WIDTH'(2))
                       && (ipPulseLength != '0)
                       && (PERIOD_WIDTH'(ipPulseLength) < ipPeriod);
    assign phase_last_c = (phase_q == (period_q - PERIOD_WIDTH'(1)));
    assign burst_last_c = (burst_q != '0) && (index_q == (burst_q - BURST_WIDTH'(1)));
    assign stop_req_c   = ipStop || !ipEnable;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q   <= IDLE;
            period_q  <= '0;
            length_q  <= '0;
            burst_q   <= '0;
            phase_q   <= '0;
            index_q   <= '0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            length_q  <= length_d;
            burst_q   <= burst_d;
            phase_q   <= phase_d;
            index_q   <= index_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; trigger is computed from the next phase so it lines up with it.
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        length_d  = length_q;
        burst_d   = burst_q;
        phase_d   = phase_q;
        index_d   = index_q;
        trigger_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (ipStart && !stop_req_c) begin
                    if (cfg_valid_c) begin
                        state_d   = RUN;
                        period_d  = ipPeriod;
                        length_d  = ipPulseLength;
                        burst_d   = ipBurstCount;
                        phase_d   = '0;
                        index_d   = '0;
                        trigger_d = 1'b1;
                        busy_d    = 1'b1;
                        err_d     = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop_req_c) begin
                    state_d = IDLE;
                end else if (phase_last_c && burst_last_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    if (phase_last_c) begin
                        phase_d = '0;
                        index_d = index_q + BURST_WIDTH'(1);
                    end else begin
                        phase_d = phase_q + PERIOD_WIDTH'(1);
                    end
                    trigger_d = (phase_d < PERIOD_WIDTH'(length_q));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign opTrigger     = trigger_q;
    assign opBusy        = busy_q;
    assign opPulseIndex  = index_q;
    assign opBurstDone   = done_q;
    assign opConfigError = err_q;

endmodule
